// File: rtl/timer_pkg.sv
// Shared types and helpers for the cascaded BCD timer: digit width,
// count direction and the load-time digit clamp.
package timer_pkg;

   localparam int BCD_W = 4;

   typedef enum logic {MODE_UP, MODE_DOWN} mode_t;

   // A preset nibble at or above its modulus is pulled down to the largest legal digit.
   function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] val,
                                                    input logic [BCD_W-1:0] mod);
      return (val >= mod) ? mod - BCD_W'(1) : val;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with a programmable modulus. It advances on its enable and
// flags wrap so the next digit up can be enabled on the same edge.
module bcd_digit
   import timer_pkg::*;
(
   input  logic             clk,
   input  logic             pulse,
   input  logic             en,
   input  mode_t            mode,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic [BCD_W-1:0] modulus,
   output logic [BCD_W-1:0] q,
   output logic             wrap
);

   logic [BCD_W-1:0] q_d, q_q;
   logic [BCD_W-1:0] top;

   assign top = modulus - BCD_W'(1);

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = clamp_digit(load_val, modulus);
      end else if (en) begin
         if (mode == MODE_UP) begin
            q_d = (q_q >= top) ? '0 : q_q + BCD_W'(1);
         end else begin
            q_d = (q_q == '0) ? top : q_q - BCD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge pulse) begin
      if (pulse) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q    = q_q;
   assign wrap = en & ((mode == MODE_UP) ? (q_q == top) : (q_q == '0));

endmodule

// File: rtl/bcd_mmss_timer.sv
// Cascaded BCD up/down timer (default MM:SS) with pause, preset load,
// a registered wrap/terminal-count carry strobe and a countdown done flag.
module bcd_mmss_timer
   import timer_pkg::*;
#(
   parameter int                     DIGITS = 4,
   parameter logic [BCD_W*DIGITS-1:0] MODULI = {4'd6, 4'd10, 4'd6, 4'd10}
) (
   input  logic                      clk,
   input  logic                      pulse,
   input  logic                      tick,
   input  logic                      us,
   input  logic                      alin,
   input  logic                      mode,
   input  logic                      load,
   input  logic [BCD_W*DIGITS-1:0]   load_val,
   output logic [BCD_W*DIGITS-1:0]   count,
   output logic                      carry_out,
   output logic                      done
);

   localparam logic [BCD_W*DIGITS-1:0] ONE = {{(BCD_W*DIGITS-1){1'b0}}, 1'b1};

   logic [DIGITS:0]   en;
   logic [DIGITS-1:0] wrap;
   logic              zero;
   logic              pause;
   logic              carry_d, carry_q;
   mode_t             mode_e;

   assign mode_e = mode ? MODE_DOWN : MODE_UP;
   assign zero   = (count == '0);
   assign pause  = us | alin;

   // Counting down saturates at zero: the tick never reaches the chain there.
   assign en[0] = tick & ~pause & ~load & ~(mode & zero);

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign en[i+1] = en[i] & wrap[i];

      bcd_digit u_digit (
         .clk      (clk),
         .pulse    (pulse),
         .en       (en[i]),
         .mode     (mode_e),
         .load     (load),
         .load_val (load_val[BCD_W*i +: BCD_W]),
         .modulus  (MODULI[BCD_W*i +: BCD_W]),
         .q        (count[BCD_W*i +: BCD_W]),
         .wrap     (wrap[i])
      );
   end

   // Up: every digit wraps together. Down: the step that lands on zero.
   always_comb begin
      carry_d = 1'b0;
      if (en[0]) begin
         if (mode_e == MODE_UP) carry_d = en[DIGITS];
         else                   carry_d = (count == ONE);
      end
   end

   always_ff @(posedge clk or posedge pulse) begin
      if (pulse) carry_q <= 1'b0;
      else       carry_q <= carry_d;
   end

   assign carry_out = carry_q;
   assign done      = mode & zero;

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Scoreboard bench for bcd_mmss_timer: an MM:SS instance checked every cycle
// against an integer-seconds model, plus a two-digit 00..99 instance.
module tb_bcd_mmss_timer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        pulse, tick, us, alin, mode, load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        carry_out, done;

   logic        tick2, mode2, load2, idle_us, idle_alin;
   logic [7:0]  load_val2;
   logic [7:0]  count2;
   logic        carry2, done2;

   bcd_mmss_timer dut (
      .clk(clk), .pulse(pulse), .tick(tick), .us(us), .alin(alin), .mode(mode),
      .load(load), .load_val(load_val), .count(count), .carry_out(carry_out), .done(done)
   );

   bcd_mmss_timer #(.DIGITS(2), .MODULI({4'd10, 4'd10})) dut2 (
      .clk(clk), .pulse(pulse), .tick(tick2), .us(idle_us), .alin(idle_alin), .mode(mode2),
      .load(load2), .load_val(load_val2), .count(count2), .carry_out(carry2), .done(done2)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Model: the count as whole seconds, digit i weighted by the product of lower moduli.
   int mods[4] = '{10, 6, 10, 6};
   int exp_val = 0;
   logic [17:0] exp_q[$];

   function automatic int to_int(input logic [15:0] b);
      int v = 0;
      for (int i = 3; i >= 0; i--) begin
         int d = int'(b[4*i +: 4]);
         if (d >= mods[i]) d = mods[i] - 1;
         v = v * mods[i] + d;
      end
      return v;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(v % mods[i]);
         v = v / mods[i];
      end
      return r;
   endfunction

   // Drives one cycle's inputs, predicts the result, then compares after the edge.
   task automatic step(input logic t, input logic l, input logic [15:0] lv);
      logic        c;
      logic [17:0] got_exp;
      tick = t; load = l; load_val = lv;
      c = 1'b0;
      if (l) begin
         exp_val = to_int(lv);
      end else if (t && !(us || alin)) begin
         if (!mode) begin
            exp_val = (exp_val + 1) % 3600;
            c = (exp_val == 0);
         end else if (exp_val != 0) begin
            exp_val = exp_val - 1;
            c = (exp_val == 0);
         end
      end
      exp_q.push_back({mode && exp_val == 0, c, to_bcd(exp_val)});
      @(posedge clk);
      #1;
      tick = 1'b0; load = 1'b0;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         got_exp = exp_q.pop_front();
         check("count", 32'(count), 32'(got_exp[15:0]));
         check("carry_out", 32'(carry_out), 32'(got_exp[16]));
         check("done", 32'(done), 32'(got_exp[17]));
      end
   endtask

   int pulses2;

   initial begin
      pulse = 1'b1; tick = 0; us = 0; alin = 0; mode = 0; load = 0; load_val = '0;
      tick2 = 0; mode2 = 0; load2 = 0; load_val2 = '0; idle_us = 0; idle_alin = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_count", 32'(count), 32'h0);
      check("reset_carry", 32'(carry_out), 32'h0);
      check("reset_done_up", 32'(done), 32'h0);
      mode = 1'b1; #1;
      check("reset_done_down", 32'(done), 32'h1);
      mode = 1'b0;
      @(posedge clk); #1;
      pulse = 1'b0;

      // Asynchronous clear mid-count, sampled well before the next edge.
      step(0, 1, 16'h1234);
      #2 pulse = 1'b1; #1;
      check("async_count", 32'(count), 32'h0);
      check("async_carry", 32'(carry_out), 32'h0);
      exp_val = 0;
      @(posedge clk); #1; pulse = 1'b0;

      // Up mode: minute rollover, full wrap, then clear while carry is high.
      step(0, 1, 16'h0959);
      step(1, 0, 16'h0);
      check("up_0959_to_1000", 32'(count), 32'h1000);
      step(0, 1, 16'h5959);
      step(1, 0, 16'h0);
      check("full_wrap_carry", 32'(carry_out), 32'h1);
      step(0, 0, 16'h0);
      repeat (3) step(1, 0, 16'h0);
      step(0, 1, 16'h5959);
      step(1, 0, 16'h0);
      #2 pulse = 1'b1; #1;
      check("async_carry_clear", 32'(carry_out), 32'h0);
      exp_val = 0;
      @(posedge clk); #1; pulse = 1'b0;

      // Down mode: borrow, terminal count, saturation, then resume upward.
      mode = 1'b1;
      step(0, 1, 16'h0100);
      step(1, 0, 16'h0);
      check("down_0100_to_0059", 32'(count), 32'h0059);
      step(0, 1, 16'h0001);
      step(1, 0, 16'h0);
      repeat (5) step(1, 0, 16'h0);
      check("down_saturated", 32'(count), 32'h0);
      mode = 1'b0;
      step(1, 0, 16'h0);

      // Pause from either source holds the count; load still acts.
      step(0, 1, 16'h0307);
      us = 1'b1;
      repeat (10) step(1, 0, 16'h0);
      us = 1'b0; alin = 1'b1;
      repeat (9) step(1, 0, 16'h0);
      step(1, 1, 16'h0307);
      alin = 1'b0;
      step(1, 0, 16'h0);
      check("resume_0308", 32'(count), 32'h0308);

      // Clamping of out-of-range nibbles, and load beating a same-edge tick.
      step(0, 1, 16'h7F9A);
      check("clamp_7F9A", 32'(count), 32'h5959);
      step(1, 1, 16'h0005);
      check("load_beats_tick", 32'(count), 32'h0005);

      // Mixed random traffic.
      for (int n = 0; n < 60; n++) begin
         mode = ($urandom_range(0, 7) == 0) ? ~mode : mode;
         us   = ($urandom_range(0, 9) == 0);
         alin = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 9) == 0)
            step(1'($urandom_range(0, 1)), 1, 16'($urandom));
         else
            step(1'($urandom_range(0, 3) != 0), 0, 16'h0);
      end
      us = 0; alin = 0;

      // Two-digit 00..99 instance: 100 ticks return to 00 with one carry.
      pulses2 = 0;
      for (int n = 0; n < 100; n++) begin
         tick2 = 1'b1;
         @(posedge clk); #1;
         tick2 = 1'b0;
         if (carry2) pulses2++;
         if (n == 36) check("two_digit_37", 32'(count2), 32'h37);
      end
      @(posedge clk); #1;
      if (carry2) pulses2++;
      check("two_digit_wrap_count", 32'(count2), 32'h0);
      check("two_digit_carry_pulses", 32'(pulses2), 32'd1);
      check("two_digit_done_up", 32'(done2), 32'h0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
